// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver: scans DIGITS digits at one per SCAN_DIV cycles,
// with double-buffered value/dp/blank and optional leading-zero suppression.
module hex_display_scanner #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [4*DIGITS-1:0]        value,
    input  logic                       load,
    input  logic [DIGITS-1:0]          dp_in,
    input  logic [DIGITS-1:0]          blank_in,
    input  logic                       lz_suppress,
    output logic [6:0]                 segment,
    output logic                       dp_out,
    output logic [DIGITS-1:0]          anode,
    output logic [$clog2(DIGITS)-1:0]  digit_idx,
    output logic                       frame_done
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Active-low segment pattern, bit6=g .. bit0=a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic                r_wrap_d;
    logic [4*DIGITS-1:0] r_shd_val;
    logic [DIGITS-1:0]   r_shd_dp;
    logic [DIGITS-1:0]   r_shd_blank;
    logic [4*DIGITS-1:0] r_dsp_val;
    logic [DIGITS-1:0]   r_dsp_dp;
    logic [DIGITS-1:0]   r_dsp_blank;
    logic [6:0]          r_segment;
    logic                r_dp_out;
    logic [DIGITS-1:0]   r_anode;
    logic [IDX_W-1:0]    r_digit_idx;
    logic                r_frame_done;

    logic                w_tick;
    logic                w_wrap;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_upper_zero;
    logic                w_dark;
    logic [6:0]          w_seg_lit;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_an_lit;
    logic                w_dp_lit;

    assign w_tick = (r_div == DIV_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);
    assign w_nib  = r_dsp_val[{r_idx, 2'b00} +: 4];

    // w_upper_zero[i] is set when every nibble from the top digit down to i is zero.
    always_comb begin : lz_scan
        logic all_zero;
        all_zero     = 1'b1;
        w_upper_zero = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero        = all_zero & (r_dsp_val[4*i +: 4] == 4'h0);
            w_upper_zero[i] = all_zero;
        end
    end

    assign w_dark    = r_dsp_blank[r_idx]
                     | (lz_suppress & (r_idx != '0) & w_upper_zero[r_idx]);
    assign w_seg_lit = SEG_ACTIVE_LOW ? hex_to_seg(w_nib) : ~hex_to_seg(w_nib);
    assign w_onehot  = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
    assign w_an_lit  = AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
    assign w_dp_lit  = r_dsp_dp[r_idx] ^ SEG_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div        <= '0;
            r_idx        <= '0;
            r_wrap_d     <= 1'b0;
            r_shd_val    <= '0;
            r_shd_dp     <= '0;
            r_shd_blank  <= '0;
            r_dsp_val    <= '0;
            r_dsp_dp     <= '0;
            r_dsp_blank  <= '0;
            r_segment    <= SEG_OFF;
            r_dp_out     <= DP_OFF;
            r_anode      <= AN_OFF;
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (load) begin
                r_shd_val   <= value;
                r_shd_dp    <= dp_in;
                r_shd_blank <= blank_in;
            end
            // A load landing on the wrap edge bypasses the shadow so it is not lost a frame.
            if (w_wrap) begin
                r_dsp_val   <= load ? value    : r_shd_val;
                r_dsp_dp    <= load ? dp_in    : r_shd_dp;
                r_dsp_blank <= load ? blank_in : r_shd_blank;
            end
            r_wrap_d     <= w_wrap;
            r_frame_done <= r_wrap_d;
            r_digit_idx  <= r_idx;
            r_segment    <= w_dark ? SEG_OFF : w_seg_lit;
            r_dp_out     <= w_dark ? DP_OFF  : w_dp_lit;
            r_anode      <= w_dark ? AN_OFF  : w_an_lit;
        end
    end

    assign segment    = r_segment;
    assign dp_out     = r_dp_out;
    assign anode      = r_anode;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Randomized and directed bench for hex_display_scanner (DIGITS=4, SCAN_DIV=4, active-low),
// compared cycle by cycle against a frame-arithmetic reference model.
module tb_hex_display_scanner;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        lz_suppress = 1'b0;
    logic [6:0]  segment;
    logic        dp_out;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_done;

    hex_display_scanner #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dp_in(dp_in),
        .blank_in(blank_in), .lz_suppress(lz_suppress), .segment(segment), .dp_out(dp_out),
        .anode(anode), .digit_idx(digit_idx), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [6:0] seg_tab [16];

    // Reference state: edges since reset release, latest loaded data, data on display.
    int          m_e = 0;
    logic [15:0] m_pend_v = '0, m_disp_v = '0;
    logic [3:0]  m_pend_dp = '0, m_pend_bl = '0, m_disp_dp = '0, m_disp_bl = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp, e_fd, dark;
        logic [1:0] e_idx;
        logic [3:0] nib;
        int         d;
        if (!reset_n) begin
            e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_idx = 2'd0; e_fd = 1'b0;
        end else begin
            d     = (m_e / SCAN_DIV) % DIGITS;
            nib   = m_disp_v[4*d +: 4];
            dark  = m_disp_bl[d] || (lz_suppress && d > 0 && (m_disp_v >> (4*d)) == 16'h0);
            e_idx = d[1:0];
            e_fd  = (m_e > 0) && (m_e % FRAME == 0);
            if (dark) begin
                e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
            end else begin
                e_seg = seg_tab[nib];
                e_an  = ~(4'b0001 << d);
                e_dp  = ~m_disp_dp[d];
            end
        end
        if (!reset_n) begin
            m_e = 0;
            m_pend_v = '0; m_pend_dp = '0; m_pend_bl = '0;
            m_disp_v = '0; m_disp_dp = '0; m_disp_bl = '0;
        end else begin
            m_e++;
            if (load) begin
                m_pend_v = value; m_pend_dp = dp_in; m_pend_bl = blank_in;
            end
            if (m_e % FRAME == 0) begin
                m_disp_v = m_pend_v; m_disp_dp = m_pend_dp; m_disp_bl = m_pend_bl;
            end
        end
        @(posedge clk);
        #1;
        check_eq("segment", 32'(segment), 32'(e_seg));
        check_eq("anode", 32'(anode), 32'(e_an));
        check_eq("dp_out", 32'(dp_out), 32'(e_dp));
        check_eq("digit_idx", 32'(digit_idx), 32'(e_idx));
        check_eq("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        value = v; dp_in = dp; blank_in = bl; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_frame();
        for (int k = 0; k < 3 * FRAME; k++) begin
            cycle();
            if (frame_done === 1'b1) return;
        end
        check_eq("frame_timeout", 32'd0, 32'd1);
    endtask

    // Called right after frame_done: checks the first cycle of each of the four slots.
    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [15:0] ans);
        for (int s = 0; s < DIGITS; s++) begin
            check_eq({tag, "_seg"}, 32'(segment), 32'(segs[7*s +: 7]));
            check_eq({tag, "_an"}, 32'(anode), 32'(ans[4*s +: 4]));
            for (int c = 0; c < SCAN_DIV; c++) cycle();
        end
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;

        // 12AF shows F, A, 2, 1 from digit 0 upward.
        cycle();
        do_load(16'h12AF, 4'h0, 4'h0);
        wait_frame();
        check_frame("r032", {7'h79, 7'h24, 7'h08, 7'h0E}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

        // Leading-zero suppression on 0050.
        lz_suppress = 1'b1;
        do_load(16'h0050, 4'h0, 4'h0);
        wait_frame();
        check_frame("r033", {7'h7F, 7'h7F, 7'h12, 7'h40}, {4'b1111, 4'b1111, 4'b1101, 4'b1110});
        lz_suppress = 1'b0;

        // Second load before the wrap overrides the first one.
        wait_frame();
        repeat (4) cycle();
        do_load(16'h1111, 4'h0, 4'h0);
        repeat (3) cycle();
        do_load(16'h2222, 4'h0, 4'h0);
        wait_frame();
        check_frame("r035", {4{7'h24}}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

        // Load in the same cycle as the wrap tick is displayed immediately.
        for (int k = 0; k < FRAME && (m_e % FRAME) != FRAME - 1; k++) cycle();
        do_load(16'h8888, 4'h0, 4'h0);
        wait_frame();
        check_frame("r036", {4{7'h00}}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

        // Reset pulse mid-frame discards the pending load.
        repeat (5) cycle();
        do_load(16'h3333, 4'hF, 4'h0);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check_eq("r037_idx", 32'(digit_idx), 32'd0);
        check_eq("r037_an", 32'(anode), 32'hF);
        wait_frame();
        check_frame("r037", {4{7'h40}}, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 63) == 0) lz_suppress = ~lz_suppress;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                cycle();
                reset_n = 1'b1;
            end else if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < DIGITS; i++)
                    value[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                dp_in    = 4'($urandom_range(0, 15));
                blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
                load     = 1'b1;
                cycle();
                load     = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed hex digits; legal range 2..8.
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range 2..2^24.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, 1 = segments/dp lit at 0.
REQ-004 Parameter AN_ACTIVE_LOW, default 1, 1 = anode selected at 0.
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 reset_n  in  1  reset is synchronous and active-low.
REQ-007 value  in  4*DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 least significant.
REQ-008 load  in  1  one-cycle strobe; captures value, dp_in, blank_in.
REQ-009 dp_in  in  DIGITS  decimal point request per digit.
REQ-010 blank_in  in  DIGITS  force digit i dark.
REQ-011 lz_suppress  in  1  leading-zero suppression enable (static level, sampled every cycle).
REQ-012 segment  out  7  bit6=g .. bit0=a, registered.
REQ-013 dp_out  out  1  decimal point, registered.
REQ-014 anode  out  DIGITS  one-hot digit select, registered.
REQ-015 digit_idx  out  $clog2(DIGITS)  index of digit currently driven.
REQ-016 frame_done  out  1  one-cycle pulse when scan wraps to digit 0.

Function
REQ-017 Divider counts 0..SCAN_DIV-1 and wraps; tick asserted in the cycle divider = SCAN_DIV-1.
REQ-018 On tick, scan index increments; from DIGITS-1 it wraps to 0 and frame_done pulses in the following cycle.
REQ-019 Load writes shadow registers (value, dp, blank) in the cycle load is high; a later load overwrites earlier unapplied data.
REQ-020 Display registers copy shadow registers only at scan wrap; if load and wrap coincide, the display takes the load-cycle inputs directly.
REQ-021 Digit i is dark if blank bit i set, or lz_suppress=1 and i>0 and every display nibble from DIGITS-1 down to i is 0.
REQ-022 Dark digit: anode all inactive, segment all off, dp_out off, for the full slot.
REQ-023 Lit digit: anode bit idx active only; segment per REQ-024; dp_out = display dp bit idx.
REQ-024 Active-low pattern (hex) 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 B=03 C=46 D=21 E=06 F=0E; inverted when SEG_ACTIVE_LOW=0.
REQ-025 Outputs update 1 cycle after the index changes; anode never has more than one active bit.
REQ-026 digit_idx, segment, anode, dp_out change together in the same cycle.
REQ-027 Digit 0 is never leading-zero suppressed; value all-zero with lz_suppress shows a single "0".

Reset
REQ-028 While reset_n=0 at a clock edge: divider=0, index=0, shadow and display registers=0, frame_done=0.
REQ-029 Reset outputs: anode all inactive, segment all off, dp_out off, digit_idx=0.
REQ-030 First tick occurs SCAN_DIV cycles after reset_n rises; from the cycle after release the block drives digit 0 of the all-zero display.
REQ-031 Reset mid-frame discards pending load data and restarts the scan at digit 0.

Verification (DIGITS=4, SCAN_DIV=4, active-low)
REQ-032 load value=16'h12AF, wait one frame -> slots 0..3 show segment 0E,08,24,79; anode 1110,1101,1011,0111.
REQ-033 value=16'h0050, lz_suppress=1 -> digits 3,2 dark (anode 1111, segment 7F); digit 1 = 12; digit 0 = 40.
REQ-034 Run 3 frames -> frame_done pulses exactly every 16 cycles, one cycle wide, coinciding with digit_idx=0 output.
REQ-035 load 16'h1111 mid-frame then 16'h2222 before wrap -> next frame shows only 24 on all digits; no 79 ever shown.
REQ-036 load coincident with wrap tick, value=16'h8888 -> the next frame displays 00 on all digits.
REQ-037 reset_n low 1 cycle mid-frame with pending load -> outputs off, digit_idx=0, pending discarded; display all zero afterwards.
